bip_sequencer: RTL and testbench

Parametrised multi-cycle control unit for the accumulator processor. It replaces the single-cycle fetch/decode control path with a FETCH/DECODE/MEM/EXEC/HALT state machine. Unlike the single-cycle path, it handshakes with instruction and data memories, supports conditional and unconditional branches, and traps illegal opcodes. It sits between program memory, data memory and the datapath (accumulator, ALU, muxes), driving the same control signals the datapath already consumes.

---
 rtl/bip_pkg.sv | 29 ++
 rtl/bip_pc.sv | 33 +++
 rtl/bip_sequencer.sv | 140 ++++++++++++++
 tb/tb_bip_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator processor control path:
// opcode values, accumulator source encodings and sequencer states.
package bip_pkg;

    localparam int unsigned OP_HLT  = 0;
    localparam int unsigned OP_STO  = 1;
    localparam int unsigned OP_LD   = 2;
    localparam int unsigned OP_LDI  = 3;
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_ADDI = 5;
    localparam int unsigned OP_SUB  = 6;
    localparam int unsigned OP_SUBI = 7;
    localparam int unsigned OP_BEQ  = 8;
    localparam int unsigned OP_BNE  = 9;
    localparam int unsigned OP_JMP  = 10;

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/bip_pc.sv
// Program counter: loads a branch target or steps by one (wrapping) when
// enabled; synchronous active-low reset to zero.
module bip_pc #(
    parameter int AB = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [AB-1:0] load_val_i,
    output logic [AB-1:0] pc_o
);

    logic [AB-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = load_i ? load_val_i : pc_q + AB'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/bip_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC/HALT control unit for the accumulator
// processor. All outputs are decoded from registered state and IR only.
module bip_sequencer
    import bip_pkg::*;
#(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int IW  = OPW + AB
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] Instr,
    input  logic          InstrValid,
    input  logic          DataReady,
    input  logic          AccZero,
    output logic [AB-1:0] Addr,
    output logic [AB-1:0] Operand,
    output logic [1:0]    SelA,
    output logic          SelB,
    output logic          Op,
    output logic          WrAcc,
    output logic          WrRam,
    output logic          RdRam,
    output logic          WrPC,
    output logic          Halted,
    output logic          Illegal,
    output state_t        State
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          illegal_q, illegal_d;
    logic [31:0]   opc;
    logic          pc_load;
    logic [AB-1:0] pc;

    assign opc = 32'(ir_q[IW-1:AB]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (InstrValid) begin
                    ir_d    = Instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Unknown opcodes flag here and then run through EXEC as a NOP.
                if (opc > OP_JMP) illegal_d = 1'b1;
                if (opc == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (opc == OP_LD || opc == OP_ADD || opc == OP_SUB) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MEM:  if (DataReady) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_FETCH;
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        SelA    = SELA_MEM;
        SelB    = 1'b0;
        Op      = 1'b0;
        WrAcc   = 1'b0;
        WrRam   = 1'b0;
        RdRam   = 1'b0;
        WrPC    = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_MEM: RdRam = 1'b1;
            ST_EXEC: begin
                WrPC = 1'b1;
                case (opc)
                    OP_STO: WrRam = 1'b1;
                    OP_LD: begin
                        WrAcc = 1'b1;
                        RdRam = 1'b1;
                    end
                    OP_LDI: begin
                        SelA  = SELA_IMM;
                        WrAcc = 1'b1;
                    end
                    // RdRam stays up so the operand read in MEM is still valid.
                    OP_ADD, OP_SUB: begin
                        SelA  = SELA_ALU;
                        WrAcc = 1'b1;
                        RdRam = 1'b1;
                        Op    = (opc == OP_SUB);
                    end
                    OP_ADDI, OP_SUBI: begin
                        SelA  = SELA_ALU;
                        SelB  = 1'b1;
                        WrAcc = 1'b1;
                        Op    = (opc == OP_SUBI);
                    end
                    OP_BEQ:  pc_load = AccZero;
                    OP_BNE:  pc_load = !AccZero;
                    OP_JMP:  pc_load = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    bip_pc #(.AB(AB)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (WrPC),
        .load_i     (pc_load),
        .load_val_i (Operand),
        .pc_o       (pc)
    );

    assign Addr    = pc;
    assign Operand = ir_q[AB-1:0];
    assign Halted  = (state_q == ST_HALT);
    assign Illegal = illegal_q;
    assign State   = state_q;

endmodule

// File: tb/tb_bip_sequencer.sv
// Directed bench for bip_sequencer: a per-cycle vector table for the
// straight-line programs plus hand-written multi-cycle corner cases.
module tb_bip_sequencer;
    import bip_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] Instr;
    logic        InstrValid;
    logic        DataReady;
    logic        AccZero;
    logic [10:0] Addr;
    logic [10:0] Operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Op;
    logic        WrAcc;
    logic        WrRam;
    logic        RdRam;
    logic        WrPC;
    logic        Halted;
    logic        Illegal;
    state_t      State;

    logic [9:0]  dut_ctrl;
    int          n_vec  = 0;
    int          n_fail = 0;

    bip_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .DataReady  (DataReady),
        .AccZero    (AccZero),
        .Addr       (Addr),
        .Operand    (Operand),
        .SelA       (SelA),
        .SelB       (SelB),
        .Op         (Op),
        .WrAcc      (WrAcc),
        .WrRam      (WrRam),
        .RdRam      (RdRam),
        .WrPC       (WrPC),
        .Halted     (Halted),
        .Illegal    (Illegal),
        .State      (State)
    );

    assign dut_ctrl = {SelA, SelB, Op, WrAcc, WrRam, RdRam, WrPC, Halted, Illegal};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ivalid;
        logic [15:0] instr;
        logic        dready;
        logic        azero;
        state_t      st;
        logic [10:0] addr;
        logic [10:0] opnd;
        logic [9:0]  ctrl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] ins_f(input int op, input int o);
        return {op[4:0], o[10:0]};
    endfunction

    // {SelA, SelB, Op, WrAcc, WrRam, RdRam, WrPC, Halted, Illegal}
    function automatic logic [9:0] mk(input logic [1:0] sa, input logic sb, input logic op,
                                      input logic wa, input logic wr, input logic rd,
                                      input logic wp, input logic h);
        return {sa, sb, op, wa, wr, rd, wp, h, 1'b0};
    endfunction

    task automatic add(input logic r, input logic iv, input logic [15:0] ins,
                       input logic dr, input logic az, input state_t st,
                       input logic [10:0] a, input logic [10:0] o, input logic [9:0] c);
        vec_t v;
        v.rst_n = r;  v.ivalid = iv; v.instr = ins; v.dready = dr; v.azero = az;
        v.st = st;    v.addr = a;    v.opnd = o;    v.ctrl = c;
        vecs.push_back(v);
    endtask

    // One non-memory instruction: DECODE, EXEC, back to FETCH at npc.
    task automatic add3(input logic [15:0] ins, input logic az, input logic [10:0] pc,
                        input logic [10:0] npc, input logic [9:0] ec,
                        input logic ip, input logic iq);
        add(1, 1, ins, 0, az, ST_DECODE, pc,  ins[10:0], {9'b0, ip});
        add(1, 1, ins, 0, az, ST_EXEC,   pc,  ins[10:0], ec | {9'b0, iq});
        add(1, 1, ins, 0, az, ST_FETCH,  npc, ins[10:0], {9'b0, iq});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    initial begin
        logic [9:0]  e_pc, e_hlt, e_ldi;
        logic [34:0] got, exp;
        int          cycles, rd_n, wa_n, mem_n;
        bit          done, wa_ok;

        rst_n = 1'b0; Instr = '0; InstrValid = 1'b0; DataReady = 1'b0; AccZero = 1'b0;

        e_pc  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        e_hlt = mk(0, 0, 0, 0, 0, 0, 0, 1);
        e_ldi = mk(1, 0, 0, 1, 0, 0, 1, 0);

        // LDI 5, ADDI 3, STO 7, HLT
        add(0, 0, '0, 0, 0, ST_FETCH, 0, 0, '0);
        add3(ins_f(3, 5), 0, 0, 1, e_ldi, 0, 0);
        add3(ins_f(5, 3), 0, 1, 2, mk(2, 1, 0, 1, 0, 0, 1, 0), 0, 0);
        add3(ins_f(1, 7), 0, 2, 3, mk(0, 0, 0, 0, 1, 0, 1, 0), 0, 0);
        add(1, 1, ins_f(0, 0), 0, 0, ST_DECODE, 3, 0, '0);
        add(1, 1, ins_f(0, 0), 0, 0, ST_HALT,   3, 0, e_hlt);
        add(1, 1, ins_f(3, 1), 1, 1, ST_HALT,   3, 0, e_hlt);
        add(1, 1, ins_f(3, 1), 1, 1, ST_HALT,   3, 0, e_hlt);
        // reset out of HALT, then branches and the PC wrap
        add(0, 1, ins_f(3, 1), 1, 1, ST_FETCH, 0, 0, '0);
        add3(ins_f(8, 'h20),  1, 0,     'h20,  e_pc, 0, 0);
        add3(ins_f(9, 'h20),  1, 'h20,  'h21,  e_pc, 0, 0);
        add3(ins_f(9, 'h30),  0, 'h21,  'h30,  e_pc, 0, 0);
        add3(ins_f(8, 'h40),  0, 'h30,  'h31,  e_pc, 0, 0);
        add3(ins_f(10, 'h7FF), 0, 'h31, 'h7FF, e_pc, 0, 0);
        add3(ins_f(3, 1),     0, 'h7FF, 0,     e_ldi, 0, 0);
        // illegal opcode at PC 4, flag sticks through SUBI
        add3(ins_f(10, 4),    0, 0, 4, e_pc, 0, 0);
        add3(ins_f(31, 'h55), 0, 4, 5, e_pc, 0, 1);
        add3(ins_f(7, 2),     0, 5, 6, mk(2, 1, 1, 1, 0, 0, 1, 0), 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n      = vecs[i].rst_n;
            InstrValid = vecs[i].ivalid;
            Instr      = vecs[i].instr;
            DataReady  = vecs[i].dready;
            AccZero    = vecs[i].azero;
            step();
            got = {State, Addr, Operand, dut_ctrl};
            exp = {vecs[i].st, vecs[i].addr, vecs[i].opnd, vecs[i].ctrl};
            n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got st=%0d addr=%h opnd=%h ctrl=%b, required st=%0d addr=%h opnd=%h ctrl=%b",
                         i, State, Addr, Operand, dut_ctrl,
                         vecs[i].st, vecs[i].addr, vecs[i].opnd, vecs[i].ctrl);
            end
        end

        // LD 9 at PC 6: DataReady low for the first 4 MEM cycles.
        Instr = ins_f(2, 9); InstrValid = 1'b1; DataReady = 1'b0;
        cycles = 0; rd_n = 0; wa_n = 0; mem_n = 0; done = 1'b0; wa_ok = 1'b0;
        while (!done && cycles < 20) begin
            step();
            cycles++;
            if (RdRam) rd_n++;
            if (WrAcc) begin
                wa_n++;
                wa_ok = RdRam && (State == ST_EXEC) && (SelA == SELA_MEM);
            end
            if (State == ST_MEM) begin
                mem_n++;
                DataReady = (mem_n >= 5);
            end else begin
                DataReady = 1'b0;
            end
            if (State == ST_FETCH) done = 1'b1;
        end
        chk("ld_done",    32'(done), 32'd1);
        chk("ld_cycles",  32'(cycles), 32'd8);
        chk("ld_rdram",   32'(rd_n), 32'd6);
        chk("ld_wracc_n", 32'(wa_n), 32'd1);
        chk("ld_wracc_q", 32'(wa_ok), 32'd1);
        chk("ld_addr",    32'(Addr), 32'h7);
        chk("ld_illegal", 32'(Illegal), 32'd1);

        // SUB 3 interrupted by reset while waiting in MEM.
        Instr = ins_f(6, 3); InstrValid = 1'b1; DataReady = 1'b0;
        step();
        chk("sub_decode", 32'(State), 32'(ST_DECODE));
        step();
        step();
        chk("sub_mem_rd", 32'({State, RdRam, WrAcc}), 32'({ST_MEM, 1'b1, 1'b0}));
        rst_n = 1'b0; DataReady = 1'b1;
        step();
        chk("rst_rdram", 32'(RdRam), 32'd0);
        chk("rst_wracc", 32'(WrAcc), 32'd0);
        rst_n = 1'b1; InstrValid = 1'b0; DataReady = 1'b0;
        step();
        chk("rst_state", 32'({State, Addr, Illegal}), 32'({ST_FETCH, 11'd0, 1'b0}));

        // FETCH must hold while InstrValid stays low.
        Instr = ins_f(3, 9);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("ivlow%0d", k), 32'({State, Addr, dut_ctrl}),
                32'({ST_FETCH, 11'd0, 10'd0}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
